spi_disp_sequencer: RTL and testbench

Command sequencer for the SPI display path. It walks a command table in a synchronous ROM and performs three jobs:
- issues the display hardware-reset pulse;
- feeds command and data bytes, with the matching A0/dc level, to the byte-level SPI engine over its load_data/busy handshake;
- inserts timed delays between bytes.

It replaces manual key-stepped byte sending: one start pulse runs a full init or update sequence and reports done or error.

---
 rtl/spi_disp_sequencer.sv | 222 ++++++++++++++++++++++
 tb/tb_spi_disp_sequencer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_disp_sequencer.sv
// Command sequencer for the SPI display path. It walks a command table held in a
// synchronous ROM and does three things: drives the display hardware-reset pulse,
// hands command/data bytes to the byte-level SPI engine over the load/busy
// handshake, and inserts timed delays between bytes.
module spi_disp_sequencer #(
  parameter int unsigned ADDR_W          = 5,
  parameter int unsigned DELAY_UNIT      = 1000,
  parameter int unsigned RST_LOW_CYCLES  = 100,
  parameter int unsigned RST_WAIT_CYCLES = 1000,
  parameter int unsigned BUSY_TIMEOUT    = 64
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              hw_reset_en,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [9:0]        rom_data,
  output logic [7:0]        spi_data,
  output logic              spi_dc,
  output logic              spi_load,
  input  logic              spi_busy,
  output logic              reset_display,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [3:0] {
    StIdle,
    StRstLo,
    StRstWait,
    StFetch,
    StDecode,
    StLoad,
    StWaitHi,
    StWaitLo,
    StDelay,
    StFin
  } state_e;

  localparam logic [1:0] OpCmd   = 2'b00;
  localparam logic [1:0] OpData  = 2'b01;
  localparam logic [1:0] OpDelay = 2'b10;
  localparam logic [1:0] OpEnd   = 2'b11;

  localparam logic [ADDR_W-1:0] LastAddr = '1;

  localparam logic [31:0] RstLowLast  = 32'(RST_LOW_CYCLES - 1);
  localparam logic [31:0] RstWaitLast = 32'(RST_WAIT_CYCLES - 1);
  localparam logic [31:0] TimeoutLast = 32'(BUSY_TIMEOUT - 1);
  localparam logic [31:0] DelayUnit   = 32'(DELAY_UNIT);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic              dc_q, dc_d;
  logic              load_q, load_d;
  logic              rstn_q, rstn_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  // Shared counter: reset-pulse length, reset wait, busy timeout and delay.
  logic [31:0]       cnt_q, cnt_d;
  logic              advance;

  // Next-state and registered-output logic for the sequencer FSM.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    dc_d    = dc_q;
    load_d  = 1'b0;
    rstn_d  = rstn_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    cnt_d   = cnt_q;
    advance = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          addr_d = start_addr;
          busy_d = 1'b1;
          if (hw_reset_en) begin
            rstn_d  = 1'b0;
            cnt_d   = RstLowLast;
            state_d = StRstLo;
          end else begin
            state_d = StFetch;
          end
        end
      end
      StRstLo: begin
        if (cnt_q == '0) begin
          rstn_d  = 1'b1;
          cnt_d   = RstWaitLast;
          state_d = StRstWait;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StRstWait: begin
        if (cnt_q == '0) begin
          state_d = StFetch;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      // ROM address is already presented; rom_data is valid in StDecode.
      StFetch: begin
        state_d = StDecode;
      end
      StDecode: begin
        unique case (rom_data[9:8])
          OpCmd, OpData: begin
            data_d  = rom_data[7:0];
            dc_d    = (rom_data[9:8] == OpData);
            state_d = StLoad;
          end
          OpDelay: begin
            cnt_d   = 32'(rom_data[7:0]) * DelayUnit;
            state_d = StDelay;
          end
          OpEnd: begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StFin;
          end
          default: ;
        endcase
      end
      StLoad: begin
        if (!spi_busy) begin
          load_d  = 1'b1;
          cnt_d   = '0;
          state_d = StWaitHi;
        end
      end
      // cnt_q counts cycles since the load pulse became visible.
      StWaitHi: begin
        if (spi_busy) begin
          state_d = StWaitLo;
        end else if (cnt_q == TimeoutLast) begin
          err_d   = 1'b1;
          busy_d  = 1'b0;
          state_d = StFin;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      StWaitLo: begin
        if (!spi_busy) begin
          advance = 1'b1;
        end
      end
      StDelay: begin
        if (cnt_q == '0) begin
          advance = 1'b1;
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Step to the next table entry; the last entry has nowhere to go.
    if (advance) begin
      if (addr_q == LastAddr) begin
        err_d   = 1'b1;
        busy_d  = 1'b0;
        state_d = StFin;
      end else begin
        addr_d  = addr_q + 1'b1;
        state_d = StFetch;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      data_q  <= '0;
      dc_q    <= 1'b0;
      load_q  <= 1'b0;
      rstn_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      dc_q    <= dc_d;
      load_q  <= load_d;
      rstn_q  <= rstn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr      = addr_q;
  assign spi_data      = data_q;
  assign spi_dc        = dc_q;
  assign spi_load      = load_q;
  assign reset_display = rstn_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_spi_disp_sequencer.sv
// Bench for spi_disp_sequencer: ROM and SPI engine models, directed scenarios and
// randomized command tables checked against a table-walking reference model.
module tb_spi_disp_sequencer;

  localparam int unsigned AW = 5;
  localparam int unsigned DU = 10;

  logic          CLK = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] start_addr;
  logic          hw_reset_en;
  logic [AW-1:0] rom_addr;
  logic [9:0]    rom_data;
  logic [7:0]    spi_data;
  logic          spi_dc;
  logic          spi_load;
  logic          spi_busy;
  logic          reset_display;
  logic          busy;
  logic          done;
  logic          err;

  int total = 0;
  int bad   = 0;

  spi_disp_sequencer #(
    .ADDR_W     (AW),
    .DELAY_UNIT (DU)
  ) dut (
    .CLK          (CLK),
    .rst          (rst),
    .start        (start),
    .start_addr   (start_addr),
    .hw_reset_en  (hw_reset_en),
    .rom_addr     (rom_addr),
    .rom_data     (rom_data),
    .spi_data     (spi_data),
    .spi_dc       (spi_dc),
    .spi_load     (spi_load),
    .spi_busy     (spi_busy),
    .reset_display(reset_display),
    .busy         (busy),
    .done         (done),
    .err          (err)
  );

  always #5 CLK = ~CLK;

  // Synchronous command ROM.
  logic [9:0] rom [0:31];
  always @(posedge CLK) rom_data <= rom[rom_addr];

  // SPI engine: busy rises one cycle after a load and stays high 16 cycles.
  int eng_cnt = 0;
  bit eng_en  = 1'b1;
  always @(posedge CLK) begin
    if (eng_cnt != 0) eng_cnt <= eng_cnt - 1;
    else if (spi_load && eng_en) eng_cnt <= 16;
  end
  assign spi_busy = (eng_cnt != 0);

  // Monitor, sampled on the falling edge.
  int         cyc = 0;
  int         n_done, n_err, rd_low, release_cyc, err_cyc;
  bit         prev_rd = 1'b1;
  bit         prev_busy = 1'b0;
  logic [8:0] got_q[$];
  int         load_cyc_q[$];
  int         fall_cyc_q[$];
  logic [8:0] exp_q[$];

  always @(negedge CLK) begin
    cyc++;
    if (spi_load === 1'b1) begin
      got_q.push_back({spi_dc, spi_data});
      load_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) n_done++;
    if (err === 1'b1) begin
      n_err++;
      err_cyc = cyc;
    end
    if (reset_display === 1'b0) rd_low++;
    if (!prev_rd && reset_display === 1'b1) release_cyc = cyc;
    if (prev_busy && !spi_busy) fall_cyc_q.push_back(cyc);
    prev_rd   = (reset_display === 1'b1);
    prev_busy = spi_busy;
  end

  // Advance to just after the monitor's sample point.
  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic clear_mon();
    n_done = 0; n_err = 0; rd_low = 0; release_cyc = 0; err_cyc = 0;
    got_q.delete(); load_cyc_q.delete(); fall_cyc_q.delete();
  endtask

  task automatic fill_end();
    for (int i = 0; i < 32; i++) rom[i] = 10'h300;
  endtask

  task automatic start_seq(input int addr, input bit hw);
    start = 1'b1; start_addr = AW'(addr); hw_reset_en = hw;
    tick();
    start = 1'b0; hw_reset_en = 1'b0;
  endtask

  task automatic wait_end(input int limit, input string name);
    int k = 0;
    while (n_done + n_err == 0 && k < limit) begin
      tick();
      k++;
    end
    if (n_done + n_err == 0) begin
      total++; bad++;
      $display("FAIL %s: no done/err within %0d cycles", name, limit);
    end
  endtask

  // Walk the table as the sequence is defined: collect bytes, stop at END or
  // flag an error when the last entry is passed without an END.
  task automatic model(input int sa, output bit e);
    int a = sa;
    bit fin = 1'b0;
    exp_q.delete();
    e = 1'b0;
    while (!fin) begin
      logic [9:0] w;
      w = rom[a];
      case (w[9:8])
        2'b00: exp_q.push_back({1'b0, w[7:0]});
        2'b01: exp_q.push_back({1'b1, w[7:0]});
        2'b11: fin = 1'b1;
        default: ;
      endcase
      if (!fin) begin
        if (a == 31) begin
          e = 1'b1;
          fin = 1'b1;
        end else begin
          a++;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    total++; if (rom_addr !== '0) begin bad++; $display("FAIL reset_rom_addr got=%h exp=0", rom_addr); end
    total++; if (spi_data !== 8'h00) begin bad++; $display("FAIL reset_spi_data got=%h exp=0", spi_data); end
    total++; if (spi_dc !== 1'b0) begin bad++; $display("FAIL reset_spi_dc got=%b exp=0", spi_dc); end
    total++; if (spi_load !== 1'b0) begin bad++; $display("FAIL reset_spi_load got=%b exp=0", spi_load); end
    total++; if (reset_display !== 1'b1) begin bad++; $display("FAIL reset_rd got=%b exp=1", reset_display); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if ({done, err} !== 2'b00) begin bad++; $display("FAIL reset_done_err got=%b exp=00", {done, err}); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    fill_end();
    rom[0] = 10'h0AE; rom[1] = 10'h155;
    clear_mon();
    start_seq(0, 1'b0);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_rise got=%b exp=1", busy); end
    wait_end(2000, "basic_wait");
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_fin got=%b exp=0", busy); end
    total++; if (got_q.size() !== 2) begin bad++; $display("FAIL basic_nloads got=%0d exp=2", got_q.size()); end
    if (got_q.size() == 2) begin
      total++; if (got_q[0] !== 9'h0AE) begin bad++; $display("FAIL basic_byte0 got=%h exp=0ae", got_q[0]); end
      total++; if (got_q[1] !== 9'h155) begin bad++; $display("FAIL basic_byte1 got=%h exp=155", got_q[1]); end
    end
    total++; if (n_done !== 1 || n_err !== 0) begin bad++; $display("FAIL basic_outcome done=%0d err=%0d exp 1/0", n_done, n_err); end
    tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
    repeat (3) tick();
  endtask

  task automatic test_hw_reset();
    clear_mon();
    start_seq(0, 1'b1);
    wait_end(5000, "hwrst_wait");
    total++; if (rd_low !== 100) begin bad++; $display("FAIL hwrst_low_len got=%0d exp=100", rd_low); end
    total++;
    if (load_cyc_q.size() == 0 || load_cyc_q[0] - release_cyc < 1000) begin
      bad++;
      $display("FAIL hwrst_first_load loads=%0d release=%0d exp gap>=1000", load_cyc_q.size(), release_cyc);
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL hwrst_done got=%0d exp=1", n_done); end
    repeat (3) tick();
  endtask

  task automatic test_delay();
    fill_end();
    rom[0] = 10'h001; rom[1] = 10'h203; rom[2] = 10'h002;
    clear_mon();
    start_seq(0, 1'b0);
    wait_end(2000, "delay_wait");
    total++;
    if (load_cyc_q.size() != 2 || fall_cyc_q.size() < 1 || load_cyc_q[1] - fall_cyc_q[0] < 30) begin
      bad++;
      $display("FAIL delay_gap loads=%0d falls=%0d exp 2 loads with gap>=30", load_cyc_q.size(), fall_cyc_q.size());
    end
    total++; if (n_done !== 1) begin bad++; $display("FAIL delay_done got=%0d exp=1", n_done); end
    repeat (3) tick();
  endtask

  task automatic test_timeout();
    fill_end();
    rom[0] = 10'h0AE;
    eng_en = 1'b0;
    clear_mon();
    start_seq(0, 1'b0);
    wait_end(500, "timeout_wait");
    total++;
    if (load_cyc_q.size() != 1 || err_cyc - load_cyc_q[0] != 64) begin
      bad++;
      $display("FAIL timeout_latency loads=%0d err_cyc=%0d exp err 64 after load", load_cyc_q.size(), err_cyc);
    end
    total++; if (n_done !== 0 || n_err !== 1) begin bad++; $display("FAIL timeout_outcome done=%0d err=%0d exp 0/1", n_done, n_err); end
    tick(); tick();
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL timeout_idle busy=%b exp=0", busy); end
    eng_en = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_no_end();
    fill_end();
    rom[31] = 10'h010;
    clear_mon();
    start_seq(31, 1'b0);
    wait_end(500, "noend_wait");
    total++;
    if (got_q.size() != 1 || got_q[0] !== 9'h010) begin
      bad++;
      $display("FAIL noend_byte loads=%0d exp one load of 010", got_q.size());
    end
    total++; if (n_err !== 1 || n_done !== 0) begin bad++; $display("FAIL noend_outcome done=%0d err=%0d exp 0/1", n_done, n_err); end
    total++; if (rom_addr !== 5'd31) begin bad++; $display("FAIL noend_nowrap rom_addr=%0d exp=31", rom_addr); end
    repeat (3) tick();
  endtask

  task automatic test_abort();
    int k = 0;
    fill_end();
    rom[0] = 10'h0AE; rom[1] = 10'h155;
    clear_mon();
    start_seq(0, 1'b0);
    while (!spi_busy && k < 50) begin tick(); k++; end
    total++; if (spi_busy !== 1'b1) begin bad++; $display("FAIL abort_engine_busy got=%b exp=1", spi_busy); end
    start = 1'b1; start_addr = 5'd7;
    repeat (3) tick();
    total++; if (rom_addr !== 5'd0 || busy !== 1'b1) begin bad++; $display("FAIL abort_start_ignored addr=%0d busy=%b exp 0/1", rom_addr, busy); end
    start = 1'b0;
    rst = 1'b1;
    tick();
    total++;
    if ({rom_addr, spi_data, spi_dc, spi_load, reset_display, busy, done, err} !== {5'd0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL abort_reset_vals addr=%0d data=%h dc=%b load=%b rd=%b busy=%b done=%b err=%b",
               rom_addr, spi_data, spi_dc, spi_load, reset_display, busy, done, err);
    end
    rst = 1'b0;
    repeat (40) tick();
    total++;
    if (got_q.size() != 1 || n_done != 0 || n_err != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_quiet loads=%0d done=%0d err=%0d busy=%b exp 1/0/0/0", got_q.size(), n_done, n_err, busy);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      int sa;
      bit hw;
      bit e;
      for (int i = 0; i < 32; i++) begin
        int r;
        r = $urandom_range(0, 15);
        if (r <= 5) rom[i] = {2'b00, 8'($urandom)};
        else if (r <= 10) rom[i] = {2'b01, 8'($urandom)};
        else if (r <= 13) rom[i] = {2'b10, 8'($urandom_range(0, 3))};
        else rom[i] = {2'b11, 8'($urandom)};
      end
      sa = $urandom_range(0, 31);
      hw = ($urandom_range(0, 3) == 0);
      model(sa, e);
      clear_mon();
      start_seq(sa, hw);
      wait_end(6000, "rand_wait");
      total++;
      if (got_q.size() != exp_q.size()) begin
        bad++;
        $display("FAIL rand%0d_count got=%0d exp=%0d", it, got_q.size(), exp_q.size());
      end
      for (int j = 0; j < got_q.size() && j < exp_q.size(); j++) begin
        total++;
        if (got_q[j] !== exp_q[j]) begin
          bad++;
          $display("FAIL rand%0d_byte%0d got=%h exp=%h", it, j, got_q[j], exp_q[j]);
        end
      end
      total++;
      if (n_err != int'(e) || n_done != int'(!e)) begin
        bad++;
        $display("FAIL rand%0d_outcome done=%0d err=%0d exp_err=%0d", it, n_done, n_err, e);
      end
      repeat (3) tick();
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start_addr = '0; hw_reset_en = 1'b0;
    fill_end();
    clear_mon();
    test_reset();
    test_basic();
    test_hw_reset();
    test_delay();
    test_timeout();
    test_no_end();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
